// File: rtl/pipearch_strided_load_pkg.sv
// Shared pipearch types: read-state enum, regs field indices, and the CCI-P channel-0 subset used by the loaders.
package pipearch_common;

   localparam int LOG2_PREFETCH_SIZE_DFLT = 9;

   localparam int REG_OFFSET  = 3;
   localparam int REG_LEN     = 4;
   localparam int REG_STRIDE  = 5;
   localparam int REG_NCHUNKS = 6;

   localparam int CL_ADDR_W = 42;
   localparam int CL_DATA_W = 512;

   typedef enum logic [1:0] {IDLE, READ, DONE} t_readstate;

   typedef logic [CL_ADDR_W-1:0] t_ccip_clAddr;

   typedef enum logic [1:0] {eCL_LEN_1 = 2'b00, eCL_LEN_2 = 2'b01, eCL_LEN_4 = 2'b11} t_ccip_clLen;

   typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;

   typedef struct packed {
      logic [15:0]  mdata;
      t_ccip_clLen  cl_len;
      t_ccip_clAddr address;
   } t_ccip_c0_ReqMemHdr;

   typedef struct packed {
      t_ccip_c0_ReqMemHdr hdr;
      logic               valid;
   } t_if_ccip_c0_Tx;

   typedef struct packed {
      t_ccip_c0_rsp resp_type;
      logic [1:0]   cl_num;
      logic [15:0]  mdata;
   } t_ccip_c0_RspMemHdr;

   typedef struct packed {
      t_ccip_c0_RspMemHdr     hdr;
      logic [CL_DATA_W-1:0]   data;
      logic                   rspValid;
   } t_if_ccip_c0_Rx;

   function automatic logic cci_c0Rx_isReadRsp(input t_if_ccip_c0_Rx r);
      return r.rspValid && (r.hdr.resp_type == eRSP_RDLINE);
   endfunction

endpackage

// File: rtl/internal_interface.sv
// Line-wide write port into the common writer: producer drives we/wdata, writer returns almostfull.
interface internal_interface #(
   parameter int WIDTH = 512
);
   logic             we;
   logic [WIDTH-1:0] wdata;
   logic             almostfull;

   modport to_commonwrite   (output we, output wdata, input almostfull);
   modport from_commonwrite (input we, input wdata, output almostfull);
endinterface

// File: rtl/pipearch_burst_select.sv
// Chooses the largest aligned burst (4/2/1 lines) that fits the chunk remainder and decides whether credits allow it.
module pipearch_burst_select
   import pipearch_common::*;
#(
   parameter int MAX_CL_LEN = 4,
   parameter int CREDIT_W   = 10
)(
   input  logic                i_enable,
   input  logic [31:0]         i_rem,
   input  logic [1:0]          i_addrLow,
   input  logic                i_multiline,
   input  logic [CREDIT_W-1:0] i_credits,
   output logic [2:0]          o_burst,
   output t_ccip_clLen         o_clLen,
   output logic                o_issue
);

   // A burst must start on its own size boundary and never run past the chunk end.
   always_comb begin
      o_burst = 3'd1;
      o_clLen = eCL_LEN_1;
      if (MAX_CL_LEN >= 4 && i_multiline && i_rem >= 32'd4 && i_addrLow == 2'b00) begin
         o_burst = 3'd4;
         o_clLen = eCL_LEN_4;
      end else if (MAX_CL_LEN >= 2 && i_multiline && i_rem >= 32'd2 && !i_addrLow[0]) begin
         o_burst = 3'd2;
         o_clLen = eCL_LEN_2;
      end
      o_issue = i_enable && (32'(i_credits) >= 32'(o_burst));
   end

endmodule

// File: rtl/pipearch_strided_load.sv
// Strided CCI-P channel-0 line loader: credit-limited aligned bursts into a prefetch FIFO, drained in order to the writer.
module pipearch_strided_load
   import pipearch_common::*;
#(
   parameter int LOG2_PREFETCH_SIZE = LOG2_PREFETCH_SIZE_DFLT,
   parameter int MAX_CL_LEN         = 4,
   parameter int CREDIT_W           = LOG2_PREFETCH_SIZE + 1
)(
   input  logic           clk,
   input  logic           reset,
   input  logic           op_start,
   output logic           op_done,
   input  logic [31:0]    regs [7],
   input  t_ccip_clAddr   in_addr,
   input  logic           c0TxAlmFull,
   input  t_if_ccip_c0_Rx cp2af_sRx_c0,
   output t_if_ccip_c0_Tx af2cp_sTx_c0,
   internal_interface.to_commonwrite into_write
);

   localparam int DEPTH = 2**LOG2_PREFETCH_SIZE;

   t_readstate r_reqState, w_reqNext, r_rxState, w_rxNext;
   t_ccip_clAddr r_chunkBase, r_curAddr;
   logic [31:0] r_chunkLen, r_stride, r_numChunks, r_linesReq, r_chunkIdx, r_totalReq;
   logic [31:0] r_lineRx, r_chunkRx;
   logic        r_multiline;
   logic [CREDIT_W-1:0] r_credits;
   t_if_ccip_c0_Tx r_tx;

   logic [CL_DATA_W-1:0] r_mem [DEPTH];
   logic [LOG2_PREFETCH_SIZE-1:0] r_wrPtr, r_rdPtr;
   logic [CREDIT_W-1:0] r_count, w_countNext;
   logic r_re, r_rvalid, r_we, r_opDone;
   logic [CL_DATA_W-1:0] r_rdata, r_wdata;

   logic        w_start, w_zeroLen, w_issue, w_chunkEnd, w_lastChunk, w_lastLine, w_fifoWe;
   logic [2:0]  w_burst;
   t_ccip_clLen w_clLen;
   logic [31:0] w_rem, w_linesAfter;
   logic        w_unused;

   assign w_start     = op_start && (r_reqState == IDLE) && (r_rxState == IDLE);
   assign w_zeroLen   = (regs[REG_LEN][30:0] == 31'd0) || (regs[REG_NCHUNKS] == 32'd0);
   assign w_rem       = r_chunkLen - r_linesReq;
   assign w_linesAfter = r_linesReq + 32'(w_burst);
   assign w_chunkEnd  = (w_linesAfter == r_chunkLen);
   assign w_lastChunk = (r_chunkIdx + 32'd1 == r_numChunks);
   assign w_lastLine  = (r_lineRx == r_chunkLen - 32'd1) && (r_chunkRx == r_numChunks - 32'd1);
   assign w_fifoWe    = cci_c0Rx_isReadRsp(cp2af_sRx_c0) && (r_rxState == READ);
   assign w_countNext = r_count + CREDIT_W'(w_fifoWe) - CREDIT_W'(r_re);
   assign w_unused    = ^{regs[0], regs[1], regs[2], cp2af_sRx_c0.hdr.mdata,
                          cp2af_sRx_c0.hdr.cl_num, r_totalReq[31:16]};

   pipearch_burst_select #(
      .MAX_CL_LEN (MAX_CL_LEN),
      .CREDIT_W   (CREDIT_W)
   ) u_burstSelect (
      .i_enable    ((r_reqState == READ) && !c0TxAlmFull),
      .i_rem       (w_rem),
      .i_addrLow   (r_curAddr[1:0]),
      .i_multiline (r_multiline),
      .i_credits   (r_credits),
      .o_burst     (w_burst),
      .o_clLen     (w_clLen),
      .o_issue     (w_issue)
   );

   // Request side finishes as soon as the final burst of the final chunk is issued.
   always_comb begin
      w_reqNext = r_reqState;
      unique case (r_reqState)
         IDLE:    if (w_start) w_reqNext = w_zeroLen ? DONE : READ;
         READ:    if (w_issue && w_chunkEnd && w_lastChunk) w_reqNext = DONE;
         DONE:    w_reqNext = IDLE;
         default: w_reqNext = IDLE;
      endcase
   end

   always_comb begin
      w_rxNext = r_rxState;
      unique case (r_rxState)
         IDLE:    if (w_start) w_rxNext = w_zeroLen ? DONE : READ;
         READ:    if (r_rvalid && w_lastLine) w_rxNext = DONE;
         DONE:    w_rxNext = IDLE;
         default: w_rxNext = IDLE;
      endcase
   end

   // Credits track free FIFO slots including lines still in flight, so issue and pop can both adjust them in one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_reqState  <= IDLE;
         r_chunkBase <= '0;
         r_curAddr   <= '0;
         r_chunkLen  <= '0;
         r_multiline <= 1'b0;
         r_stride    <= '0;
         r_numChunks <= '0;
         r_linesReq  <= '0;
         r_chunkIdx  <= '0;
         r_totalReq  <= '0;
         r_credits   <= CREDIT_W'(DEPTH);
         r_tx        <= '0;
      end else begin
         r_reqState <= w_reqNext;
         r_credits  <= r_credits - (w_issue ? CREDIT_W'(w_burst) : '0) + CREDIT_W'(r_re);
         r_tx.valid <= w_issue;
         if (w_issue) begin
            r_tx.hdr.address <= r_curAddr;
            r_tx.hdr.cl_len  <= w_clLen;
            r_tx.hdr.mdata   <= r_totalReq[15:0];
         end else begin
            r_tx.hdr <= '0;
         end
         if (w_start) begin
            r_chunkBase <= in_addr + t_ccip_clAddr'(regs[REG_OFFSET]);
            r_curAddr   <= in_addr + t_ccip_clAddr'(regs[REG_OFFSET]);
            r_chunkLen  <= {1'b0, regs[REG_LEN][30:0]};
            r_multiline <= regs[REG_LEN][31];
            r_stride    <= regs[REG_STRIDE];
            r_numChunks <= regs[REG_NCHUNKS];
            r_linesReq  <= '0;
            r_chunkIdx  <= '0;
         end else if (w_issue) begin
            r_totalReq <= r_totalReq + 32'(w_burst);
            if (w_chunkEnd) begin
               r_chunkBase <= r_chunkBase + t_ccip_clAddr'(r_stride);
               r_curAddr   <= r_chunkBase + t_ccip_clAddr'(r_stride);
               r_linesReq  <= '0;
               r_chunkIdx  <= r_chunkIdx + 32'd1;
            end else begin
               r_curAddr  <= r_curAddr + t_ccip_clAddr'(w_burst);
               r_linesReq <= w_linesAfter;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_fifoWe) r_mem[r_wrPtr] <= cp2af_sRx_c0.data;
      if (r_re) r_rdata <= r_mem[r_rdPtr];
      r_wdata <= r_rdata;
   end

   // The pop request looks at occupancy after this cycle's push/pop so a registered re never pops an empty FIFO.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr  <= '0;
         r_rdPtr  <= '0;
         r_count  <= '0;
         r_re     <= 1'b0;
         r_rvalid <= 1'b0;
      end else begin
         if (w_fifoWe) r_wrPtr <= r_wrPtr + 1'b1;
         if (r_re) r_rdPtr <= r_rdPtr + 1'b1;
         r_count  <= w_countNext;
         r_re     <= (w_countNext != '0) && !into_write.almostfull;
         r_rvalid <= r_re;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rxState <= IDLE;
         r_lineRx  <= '0;
         r_chunkRx <= '0;
         r_we      <= 1'b0;
         r_opDone  <= 1'b0;
      end else begin
         r_rxState <= w_rxNext;
         r_we      <= r_rvalid && (r_rxState == READ);
         r_opDone  <= (r_rxState == DONE);
         if (w_start) begin
            r_lineRx  <= '0;
            r_chunkRx <= '0;
         end else if (r_rvalid && r_rxState == READ) begin
            if (r_lineRx == r_chunkLen - 32'd1) begin
               r_lineRx  <= '0;
               r_chunkRx <= r_chunkRx + 32'd1;
            end else begin
               r_lineRx <= r_lineRx + 32'd1;
            end
         end
      end
   end

   assign af2cp_sTx_c0     = r_tx;
   assign op_done          = r_opDone;
   assign into_write.we    = r_we;
   assign into_write.wdata = r_wdata;

endmodule
